// File: rtl/seq_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude-compare driver.
package seq_cmp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One-hot {L,E,G} answers from the comparator.
  localparam logic [2:0] LEG_LESS = 3'b100;
  localparam logic [2:0] LEG_EQ   = 3'b010;
  localparam logic [2:0] LEG_GT   = 3'b001;
  localparam logic [2:0] LEG_NONE = 3'b000;

endpackage

// File: rtl/seq_compare_driver_piso2_shift.sv
// Two-lane parallel-load, MSB-first shift register. Zeros shift in from the
// LSB end. Exposes the current MSB and the bit that becomes MSB after the
// next shift, so the caller can register the serial output one cycle ahead.
module piso2_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] a_load,
  input  logic [WIDTH-1:0] b_load,
  output logic             a_msb,
  output logic             b_msb,
  output logic             a_nmsb,
  output logic             b_nmsb
);

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;

  // Load has priority over shift; both lanes move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
    end else if (load) begin
      a_sr <= a_load;
      b_sr <= b_load;
    end else if (shift) begin
      a_sr <= a_sr << 1;
      b_sr <= b_sr << 1;
    end
  end

  assign a_msb = a_sr[WIDTH-1];
  assign b_msb = b_sr[WIDTH-1];

  if (WIDTH > 1) begin : g_next
    assign a_nmsb = a_sr[WIDTH-2];
    assign b_nmsb = b_sr[WIDTH-2];
  end else begin : g_next1
    assign a_nmsb = 1'b0;
    assign b_nmsb = 1'b0;
  end

endmodule

// File: rtl/seq_compare_driver.sv
// Initiator for the bit-serial magnitude comparator: clears it, streams both
// operands MSB-first, strobes op on the closing cycle and captures {L,E,G}.
// The comparator's reset must be wired as rst | cmp_rst at the level above.
// Optional macro SEQ_CMP_ONEHOT_CHECK_EN enables the one-hot check on err.
module seq_compare_driver
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result,
  output logic             err,
  output logic             cmp_rst,
  output logic             a_bit,
  output logic             b_bit,
  output logic             op,
  input  logic [2:0]       cmp_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic [CW-1:0]   cnt;
  logic            a_msb, b_msb, a_nmsb, b_nmsb;

  piso2_shift #(.WIDTH(WIDTH)) u_sr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .shift  (state == SHIFT),
    .a_load (a_in),
    .b_load (b_in),
    .a_msb  (a_msb),
    .b_msb  (b_msb),
    .a_nmsb (a_nmsb),
    .b_nmsb (b_nmsb)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = CLEAR;
      end
      CLEAR: state_next = SHIFT;
      SHIFT: if (cnt == '0) state_next = FINAL;
      FINAL: state_next = DONE;
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CLEAR;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CLEAR) || (state == SHIFT) || (state == FINAL);

  // Registered outputs are decoded from the next state so they line up with
  // the state they belong to; the serial bits are taken one shift early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_rst <= 1'b0;
      op      <= 1'b0;
      done    <= 1'b0;
      a_bit   <= 1'b0;
      b_bit   <= 1'b0;
      result  <= LEG_NONE;
      cnt     <= '0;
    end else begin
      cmp_rst <= (state_next == CLEAR);
      op      <= (state_next == FINAL);
      done    <= (state_next == DONE);
      if (state_next == SHIFT) begin
        a_bit <= (state == CLEAR) ? a_msb : a_nmsb;
        b_bit <= (state == CLEAR) ? b_msb : b_nmsb;
      end else begin
        a_bit <= 1'b0;
        b_bit <= 1'b0;
      end
      if (accept)              result <= LEG_NONE;
      else if (state == FINAL) result <= cmp_out;
      if (accept)                           cnt <= CW'(WIDTH - 1);
      else if (state == SHIFT && cnt != '0) cnt <= cnt - CW'(1);
    end
  end

`ifdef SEQ_CMP_ONEHOT_CHECK_EN
  // Flag a comparator answer that is not exactly one-hot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err <= 1'b0;
    else if (accept)         err <= 1'b0;
    else if (state == FINAL) err <= !((cmp_out == LEG_LESS) ||
                                      (cmp_out == LEG_EQ)   ||
                                      (cmp_out == LEG_GT));
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_compare_driver.sv
// Directed bench for seq_compare_driver with a behavioural serial comparator.
module tb_seq_compare_driver;

  localparam int W = 8;

`ifdef SEQ_CMP_ONEHOT_CHECK_EN
  localparam logic EXP_ERR_NONE = 1'b1;
`else
  localparam logic EXP_ERR_NONE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, err, cmp_rst, a_bit, b_bit, op;
  logic [2:0]   result;
  logic [2:0]   cmp_out;

  int checks = 0;
  int failures = 0;

  seq_compare_driver #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err),
    .cmp_rst (cmp_rst),
    .a_bit   (a_bit),
    .b_bit   (b_bit),
    .op      (op),
    .cmp_out (cmp_out)
  );

  always #5 clk = ~clk;

  // Behavioural sequential comparator: first differing bit decides.
  logic       force_none = 1'b0;
  logic [2:0] leg;
  wire        crst = rst | cmp_rst;

  always_ff @(posedge clk or posedge crst) begin
    if (crst) leg <= 3'b010;
    else if (!op && leg == 3'b010 && a_bit != b_bit)
      leg <= a_bit ? 3'b001 : 3'b100;
  end

  assign cmp_out = (op && !force_none) ? leg : 3'b000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is seen by the following rising edge (E0).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge inside cycle 1; walks cycles 1..W+3.
  task automatic observe(input string tn, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [2:0] eres, input logic eerr, input bit glitch,
                         input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb);
    int busy_n = 0, crst_n = 0, op_n = 0, done_n = 0;
    logic [W-1:0] as = '0, bs = '0;
    logic crst_c1 = 1'b0, op_c = 1'b0, done_c = 1'b0, err_c = 1'b0;
    logic [2:0] res_c = 3'b000;
    for (int k = 1; k <= W + 3; k++) begin
      busy_n += int'(busy);
      crst_n += int'(cmp_rst);
      op_n   += int'(op);
      done_n += int'(done);
      if (k == 1) crst_c1 = cmp_rst;
      if (k >= 2 && k <= W + 1) begin
        as = {as[W-2:0], a_bit};
        bs = {bs[W-2:0], b_bit};
      end
      if (k == W + 2) op_c = op;
      if (k == W + 3) begin
        done_c = done;
        res_c  = result;
        err_c  = err;
      end
      if (glitch && k == 4) begin
        start = 1'b1;
        a_in  = ~ea;
        b_in  = ~eb;
      end
      if (glitch && k == 5) start = 1'b0;
      if (chain && k == W + 3) begin
        start = 1'b1;
        a_in  = na;
        b_in  = nb;
      end
      @(negedge clk);
      if (chain && k == W + 3) start = 1'b0;
    end
    check_eq({tn, ".cmp_rst_c1"}, 32'(crst_c1), 32'd1);
    check_eq({tn, ".cmp_rst_n"},  32'(crst_n),  32'd1);
    check_eq({tn, ".busy_n"},     32'(busy_n),  32'(W + 2));
    check_eq({tn, ".a_seq"},      32'(as),      32'(ea));
    check_eq({tn, ".b_seq"},      32'(bs),      32'(eb));
    check_eq({tn, ".op_final"},   32'(op_c),    32'd1);
    check_eq({tn, ".op_n"},       32'(op_n),    32'd1);
    check_eq({tn, ".done"},       32'(done_c),  32'd1);
    check_eq({tn, ".done_n"},     32'(done_n),  32'd1);
    check_eq({tn, ".result"},     32'(res_c),   32'(eres));
    check_eq({tn, ".err"},        32'(err_c),   32'(eerr));
  endtask

  task automatic check_reset_vals(input string tn);
    check_eq({tn, ".busy"},    32'(busy),    32'd0);
    check_eq({tn, ".done"},    32'(done),    32'd0);
    check_eq({tn, ".result"},  32'(result),  32'd0);
    check_eq({tn, ".err"},     32'(err),     32'd0);
    check_eq({tn, ".cmp_rst"}, 32'(cmp_rst), 32'd0);
    check_eq({tn, ".bits"},    32'({a_bit, b_bit}), 32'd0);
    check_eq({tn, ".op"},      32'(op),      32'd0);
  endtask

  initial begin
    int done_seen;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: equal operands
    launch(8'h5A, 8'h5A);
    observe("t1", 8'h5A, 8'h5A, 3'b010, 1'b0, 1'b0, 1'b0, '0, '0);

    // 2: A greater, then result must hold in idle
    launch(8'h80, 8'h7F);
    observe("t2", 8'h80, 8'h7F, 3'b001, 1'b0, 1'b0, 1'b0, '0, '0);
    check_eq("t2.hold", 32'(result), 32'h1);

    // 3: A less
    launch(8'h03, 8'h04);
    observe("t3", 8'h03, 8'h04, 3'b100, 1'b0, 1'b0, 1'b0, '0, '0);

    // 4: start glitch during SHIFT ignored, back-to-back start in DONE
    launch(8'h10, 8'h20);
    observe("t4a", 8'h10, 8'h20, 3'b100, 1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
    observe("t4b", 8'h01, 8'h00, 3'b001, 1'b0, 1'b0, 1'b0, '0, '0);

    // 5: reset in the 4th SHIFT cycle (cycle 5)
    launch(8'h5A, 8'h3C);
    repeat (4) @(negedge clk);
    check_eq("t5.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("t5.abort");
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      done_seen += int'(done);
      @(negedge clk);
    end
    check_eq("t5.no_done", 32'(done_seen), 32'd0);
    launch(8'hFF, 8'hFF);
    observe("t5b", 8'hFF, 8'hFF, 3'b010, 1'b0, 1'b0, 1'b0, '0, '0);

    // 6: comparator returns no answer
    force_none = 1'b1;
    launch(8'h12, 8'h34);
    observe("t6", 8'h12, 8'h34, 3'b000, EXP_ERR_NONE, 1'b0, 1'b0, '0, '0);
    force_none = 1'b0;

    // 7: err clears on the next accepted start
    launch(8'h34, 8'h12);
    observe("t7", 8'h34, 8'h12, 3'b001, 1'b0, 1'b0, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_compare_driver.md
# seq_compare_driver

Initiator side of the bit-serial magnitude-compare interface. It accepts two parallel WIDTH-bit unsigned operands, clears the downstream sequential comparator, streams both operands MSB-first on `a_bit`/`b_bit`, asserts `op` for the closing cycle, and captures the comparator's one-hot L-E-G answer. It sits between a parallel requester (start/busy/done handshake) and one comparator instance.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits; legal range ≥ 1.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `a_in`  input  WIDTH  operand A, captured on an accepted `start`.
- `b_in`  input  WIDTH  operand B, captured on an accepted `start`.
- `busy`  output  1  high from the CLEAR cycle through the FINAL cycle.
- `done`  output  1  one-cycle pulse when `result` becomes valid.
- `result`  output  3  captured {L,E,G}; holds its value until the next accepted `start`.
- `err`  output  1  protocol-check flag; valid with `done`.
- `cmp_rst`  output  1  registered clear pulse for the comparator.
- `a_bit`  output  1  current bit of A.
- `b_bit`  output  1  current bit of B.
- `op`  output  1  final-cycle strobe; the comparator ignores the bits in this cycle.
- `cmp_out`  input  3  comparator {L,E,G} output; combinational and valid only while `op`=1.

## Operation
FSM states are IDLE, CLEAR, SHIFT, FINAL, DONE.

- **IDLE**
  - `start`=1: load `a_in` and `b_in` into the shift registers, set `cnt`=WIDTH-1, go to CLEAR.
  - Otherwise stay in IDLE.
- **CLEAR** (one cycle): `cmp_rst`=1, `busy`=1. Go to SHIFT.
- **SHIFT** (WIDTH cycles)
  - Outputs: `a_bit`=A_sr[WIDTH-1], `b_bit`=B_sr[WIDTH-1], `op`=0.
  - Each edge: shift both registers left by 1, decrement `cnt`.
  - When `cnt`=0 at the edge, go to FINAL.
- **FINAL** (one cycle)
  - Outputs: `op`=1, `a_bit`=`b_bit`=0.
  - At the closing edge: `result`←`cmp_out`, then go to DONE.
- **DONE** (one cycle): `done`=1, `busy`=0.
  - `start`=1: accept as in IDLE and go to CLEAR (back-to-back operation).
  - Otherwise go to IDLE.
- `start` during CLEAR, SHIFT or FINAL is ignored; operands are not re-sampled.
- WIDTH=1: SHIFT lasts exactly one cycle.
- `cnt` width is $clog2(WIDTH+1); it never wraps below 0 because the exit happens at 0.
- All outputs are registered except `busy`, which is decoded from state.

## Timing
- Start accepted at edge E0. Then:
  - cycle 1: CLEAR
  - cycles 2..WIDTH+1: data bits
  - cycle WIDTH+2: `op`=1
  - cycle WIDTH+3: `done`=1
- Latency from start to `done` is WIDTH+3 cycles; throughput is one compare per WIDTH+3 cycles with back-to-back starts.
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=3'b000, `err`=0, `cmp_rst`=0, `a_bit`=0, `b_bit`=0, `op`=0, shift registers and `cnt` zero.
- `rst` asserted mid-operation returns everything to reset values immediately (asynchronously). No `done` is produced for the aborted operation. The comparator is also cleared, because the top level drives its reset with `rst | cmp_rst`.

## Configuration
- `SEQ_CMP_ONEHOT_CHECK_EN` defined:
  - In FINAL, `err` is set if `cmp_out` is not exactly one of 3'b100, 3'b010, 3'b001.
  - `err` is registered together with `result` and cleared on the next accepted `start`.
- Not defined: `err` is tied to 0 and no check logic is generated.

## Structure
- Shared package `seq_cmp_pkg` holds:
  - the state enum (IDLE, CLEAR, SHIFT, FINAL, DONE);
  - the result constants LEG_LESS=3'b100, LEG_EQ=3'b010, LEG_GT=3'b001, LEG_NONE=3'b000.
- One sub-module, `piso2_shift`: a two-lane parallel-load, MSB-first shift register with load and shift enables. It is instantiated once for both operands.
- The top-level wiring is comparator `rst` = `rst | cmp_rst`.

## Test plan
1. WIDTH=8, A=0x5A, B=0x5A, start at E0 → `a_bit`/`b_bit` sequence 0,1,0,1,1,0,1,0 in cycles 2–9; `op`=1 in cycle 10; `done` in cycle 11 with `result`=3'b010.
2. A=0x80, B=0x7F → `result`=3'b001 (G); `cmp_rst` high in exactly one cycle.
3. A=0x03, B=0x04 → `result`=3'b100 (L); `busy` high for exactly 10 cycles.
4. `start` pulses during SHIFT are ignored, and a new `start` held high in the DONE cycle is accepted → the second operation (A=0x01, B=0x00) yields `result`=3'b001 with no idle gap.
5. `rst` asserted in the 4th SHIFT cycle → all outputs go to reset values immediately; no `done`; the next start (A=B=0xFF) yields 3'b010.
6. Comparator model forced to drive `cmp_out`=3'b000 during FINAL:
   - with `SEQ_CMP_ONEHOT_CHECK_EN` → `err`=1 with `done`;
   - without it → `err`=0.
